// File: rtl/rv32i_types.sv
// Shared RV32I types for the MEM stage: word type, load/store funct3 encodings,
// the memory-access FSM states and the access alignment rule.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_acc_state_t;

  // Bytes never fault; halves need an even offset; words (and unknown widths) need offset 0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] bit_shift);
    logic m;
    case (funct3[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = bit_shift[0];
      default: m = (bit_shift != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Selects the addressed byte/half/word of the read data and sign- or zero-extends it.
module load_aligner
  import rv32i_types::*;
(
  input  rv32i_word   rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  bit_shift_i,
  output rv32i_word   load_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata_i[{bit_shift_i, 3'b000} +: 8];
  assign half_s = rdata_i[{bit_shift_i[1], 4'b0000} +: 16];

  // Extension select; unknown encodings fall back to a full word.
  always_comb begin
    case (funct3_i)
      LB:      load_data_o = {{24{byte_s[7]}}, byte_s};
      LBU:     load_data_o = {24'h000000, byte_s};
      LH:      load_data_o = {{16{half_s[15]}}, half_s};
      LHU:     load_data_o = {16'h0000, half_s};
      LW:      load_data_o = rdata_i;
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: issues one dmem request per load/store, stalls
// the pipeline until dmem_resp, and presents the extended load result to MEM/WB.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [2:0]             funct3_in,
  input  logic [31:0]            addr_in,
  input  logic [1:0]             bit_shift_in,
  input  logic [3:0]             byte_en_in,
  input  logic [31:0]            wdata_in,
  input  logic                   advance,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [31:0]            dmem_address,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_byte_enable,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp,
  output logic                   stall,
  output logic [31:0]            load_data,
  output logic                   misaligned,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  mem_acc_state_t         state_q, state_d;
  logic                   read_q, read_d, write_q, write_d;
  rv32i_word              addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0]             be_q, be_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             bs_q, bs_d;
  logic                   misal_q, misal_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   op_s, misal_s;
  rv32i_word              aligned_s;

  assign op_s    = mem_read_in | mem_write_in;
  assign misal_s = is_misaligned(funct3_in, bit_shift_in);
  assign stall   = op_s && (state_q != DONE);

  load_aligner u_load_aligner (
    .rdata_i     (dmem_rdata),
    .funct3_i    (funct3_q),
    .bit_shift_i (bs_q),
    .load_data_o (aligned_s)
  );

  // Next-state and request-field logic; a load takes priority when both op bits are set.
  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    bs_d     = bs_q;
    load_d   = load_q;
    misal_d  = misal_q;
    case (state_q)
      IDLE: begin
        if (op_s && !misal_s) begin
          state_d  = BUSY;
          read_d   = mem_read_in;
          write_d  = !mem_read_in;
          addr_d   = addr_in;
          funct3_d = funct3_in;
          bs_d     = bit_shift_in;
          if (mem_read_in) begin
            wdata_d = 32'h0000_0000;
            be_d    = 4'b0000;
          end else begin
            wdata_d = wdata_in << {bit_shift_in, 3'b000};
            be_d    = byte_en_in;
          end
        end else if (op_s) begin
          state_d = DONE;
          misal_d = 1'b1;
          load_d  = 32'h0000_0000;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          state_d = DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            load_d = aligned_s;
          end else begin
            load_d = load_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (advance) begin
          state_d = IDLE;
          misal_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, request, result and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'b0000;
      funct3_q    <= 3'b000;
      bs_q        <= 2'b00;
      load_q      <= 32'h0000_0000;
      misal_q     <= 1'b0;
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      funct3_q    <= funct3_d;
      bs_q        <= bs_d;
      load_q      <= load_d;
      misal_q     <= misal_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_read        = read_q;
  assign dmem_write       = write_q;
  assign dmem_address     = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign load_data        = load_q;
  assign misaligned       = misal_q;
  assign stall_cycles     = stall_cnt_q;

endmodule
